// File: rtl/data_mem_responder.sv
// data_mem_responder: slave end of the core's load/store port.
// Accepts one request at a time on a valid/ready channel, commits stores at
// acceptance, then returns a response after WAIT_STATES cycles on a second
// valid/ready channel. Misaligned or out-of-range accesses report rsp_err.
module data_mem_responder #(
   parameter int W           = 32,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic         req_we,
   input  logic [W-1:0] req_addr,
   input  logic [W-1:0] req_wdata,
   input  logic [3:0]   req_be,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [W-1:0] rsp_rdata,
   output logic         rsp_err
);

   localparam int           AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [W-1:0] LIMIT = W'(DEPTH * 4);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t         r_state, w_next;
   logic [7:0]     r_cnt;
   logic [W-1:0]   r_rdata;
   logic           r_err;
   logic [W-1:0]   r_mem [DEPTH];

   logic           w_accept;
   logic           w_err;
   logic [AW-1:0]  w_idx;

   assign req_ready = (r_state == S_IDLE) && !rst;
   assign w_accept  = req_valid && req_ready;
   assign w_err     = (req_addr[1:0] != 2'b00) || (req_addr >= LIMIT);
   assign w_idx     = req_addr[AW+1:2];

   // rsp_valid is simply "in RESP"; the state register already gives it a clean edge
   assign rsp_valid = (r_state == S_RESP);
   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state: accept -> (WAIT ->) RESP -> IDLE on response handshake
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_next = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
         S_WAIT: if (r_cnt == 8'd1) w_next = S_RESP;
         S_RESP: if (rsp_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Wait-state counter: loaded at acceptance, counts down while waiting
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                    r_cnt <= 8'd0;
      else if (w_accept)          r_cnt <= 8'(WAIT_STATES);
      else if (r_state == S_WAIT) r_cnt <= r_cnt - 8'd1;
   end

   // Response payload: captured at acceptance, held through RESP, cleared on handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else if (w_accept) begin
         r_rdata <= (!req_we && !w_err) ? r_mem[w_idx] : '0;
         r_err   <= w_err;
      end else if (r_state == S_RESP && rsp_ready) begin
         r_rdata <= '0;
         r_err   <= 1'b0;
      end
   end

   // Store commit at acceptance; not reset so a store survives a later rst
   always_ff @(posedge clk) begin
      if (w_accept && req_we && !w_err) begin
         for (int i = 0; i < 4; i++)
            if (req_be[i]) r_mem[w_idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one WAIT_STATES=2 instance covering
// store/load, byte lanes, errors, backpressure and reset, plus a
// WAIT_STATES=0 instance for back-to-back throughput.
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        req_valid = 0, req_we = 0, rsp_ready = 0;
   logic [31:0] req_addr = 0, req_wdata = 0;
   logic [3:0]  req_be = 0;
   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;

   logic        req_valid0 = 0, req_we0 = 0, rsp_ready0 = 1;
   logic [31:0] req_addr0 = 0, req_wdata0 = 0;
   logic [3:0]  req_be0 = 0;
   logic        req_ready0, rsp_valid0, rsp_err0;
   logic [31:0] rsp_rdata0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   data_mem_responder #(.W(32), .DEPTH(256), .WAIT_STATES(2)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   data_mem_responder #(.W(32), .DEPTH(256), .WAIT_STATES(0)) u_dut0 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
      .req_addr(req_addr0), .req_wdata(req_wdata0), .req_be(req_be0),
      .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
      .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction on the WAIT_STATES=2 instance. While the
   // transaction is in flight a decoy store is presented and must be ignored.
   task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] exp_rdata,
                       input logic exp_err, input int hold);
      chk("req_ready_idle", req_ready, 1);
      req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
      tick();
      req_we = 1; req_addr = 32'h10; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
      chk("lat_e0_valid", rsp_valid, 0);
      chk("lat_e0_ready", req_ready, 0);
      tick();
      chk("lat_e1_valid", rsp_valid, 0);
      tick();
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_rdata", rsp_rdata, exp_rdata);
      chk("rsp_err", rsp_err, exp_err);
      chk("req_ready_resp", req_ready, 0);
      for (int i = 0; i < hold; i++) begin
         tick();
         chk("hold_valid", rsp_valid, 1);
         chk("hold_rdata", rsp_rdata, exp_rdata);
         chk("hold_err", rsp_err, exp_err);
         chk("hold_ready", req_ready, 0);
      end
      rsp_ready = 1;
      tick();
      rsp_ready = 0;
      chk("post_valid", rsp_valid, 0);
      chk("post_ready", req_ready, 1);
      chk("post_rdata", rsp_rdata, 0);
      chk("post_err", rsp_err, 0);
      req_valid = 0;
   endtask

   // One transaction on the WAIT_STATES=0 instance; req_valid0 stays high so
   // the handshake edge must not accept anything.
   task automatic x0(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata);
      chk("w0_ready", req_ready0, 1);
      req_valid0 = 1; req_we0 = we; req_addr0 = addr; req_wdata0 = wdata; req_be0 = 4'hF;
      tick();
      chk("w0_valid", rsp_valid0, 1);
      chk("w0_rdata", rsp_rdata0, exp_rdata);
      chk("w0_busy", req_ready0, 0);
      tick();
      chk("w0_done", rsp_valid0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      #1;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rdata", rsp_rdata, 0);
      chk("rst_err", rsp_err, 0);
      tick();
      chk("rst_req_ready_clk", req_ready, 0);
      rst = 0;
      #1;
      chk("rel_req_ready", req_ready, 1);

      // Store then load
      xact(1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0, 0);
      xact(0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0, 0);

      // Byte lanes, including an all-disabled store
      xact(1, 32'h20, 32'h11223344, 4'hF, 32'h0, 0, 0);
      xact(1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 0, 0);
      xact(0, 32'h20, 32'h0, 4'hF, 32'h11BB33DD, 0, 0);
      xact(1, 32'h20, 32'hFFFFFFFF, 4'h0, 32'h0, 0, 0);
      xact(0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 0, 0);

      // Errors: misaligned load, out-of-range store, misaligned store
      xact(0, 32'h13, 32'h0, 4'hF, 32'h0, 1, 0);
      xact(1, 32'h0, 32'h01020304, 4'hF, 32'h0, 0, 0);
      xact(1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0, 1, 0);
      xact(0, 32'h0, 32'h0, 4'h0, 32'h01020304, 0, 0);
      xact(1, 32'h12, 32'h0, 4'hF, 32'h0, 1, 0);
      xact(0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0, 0);
      xact(0, 32'h400, 32'h0, 4'h0, 32'h0, 1, 0);
      // Last valid word
      xact(1, 32'h3FC, 32'h89ABCDEF, 4'hF, 32'h0, 0, 0);
      xact(0, 32'h3FC, 32'h0, 4'h0, 32'h89ABCDEF, 0, 0);

      // Backpressure: response held for 5 cycles
      xact(0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0, 5);

      // Reset during WAIT: store stays committed, response is dropped
      req_valid = 1; req_we = 1; req_addr = 32'h8; req_wdata = 32'h5A5A5A5A; req_be = 4'hF;
      tick();
      req_valid = 0;
      rst = 1;
      #1;
      chk("mid_rst_ready", req_ready, 0);
      chk("mid_rst_valid", rsp_valid, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("mid_rst_valid_clk", rsp_valid, 0);
         chk("mid_rst_ready_clk", req_ready, 0);
      end
      rst = 0;
      #1;
      chk("after_rst_ready", req_ready, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("after_rst_valid", rsp_valid, 0);
      end
      xact(0, 32'h8, 32'h0, 4'h0, 32'h5A5A5A5A, 0, 0);

      // WAIT_STATES=0: back-to-back with rsp_ready tied high
      x0(1, 32'h4, 32'h12345678, 32'h0);
      x0(1, 32'h8, 32'h9ABCDEF0, 32'h0);
      x0(0, 32'h4, 32'h0, 32'h12345678);
      x0(0, 32'h8, 32'h0, 32'h9ABCDEF0);
      x0(0, 32'h6, 32'h0, 32'h0);
      chk("w0_err_flag_cleared", rsp_err0, 0);
      req_valid0 = 0;
      tick();
      chk("w0_idle", rsp_valid0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Handshaked data-memory responder: the slave end of the core's load/store interface.
- Replaces the ideal always-ready data memory with a valid/ready request channel and a valid/ready response channel.
- Supports configurable wait states, byte-lane writes, and error reporting for misaligned or out-of-range accesses.
- Serves one transaction at a time.

Parameters:
W, 32, data and address width; byte-lane logic is defined for 32 only.
DEPTH, 256, number of 32-bit words stored; valid byte addresses are 0 to DEPTH*4-1.
WAIT_STATES, 2, extra cycles between request acceptance and rsp_valid; legal range 0..255.

Ports:
clk  in  1  clock; all state changes on rising edge.
rst  in  1  reset, asynchronous, active-high.
req_valid  in  1  initiator presents a request.
req_ready  out  1  responder can accept a request.
req_we  in  1  1 = store, 0 = load.
req_addr  in  W  byte address.
req_wdata  in  W  store data.
req_be  in  4  byte enables; bit i enables bits 8i+7:8i (little-endian).
rsp_valid  out  1  response available.
rsp_ready  in  1  initiator accepts the response.
rsp_rdata  out  W  load data; 0 for stores and errors.
rsp_err  out  1  access was misaligned or out of range.

Behaviour:
- Reset (asynchronous, active-high) forces the following:
  - state IDLE, wait counter 0.
  - rsp_valid 0, rsp_rdata 0, rsp_err 0.
  - req_ready 0 while rst is high.
- Memory array is not cleared by rst; simulation initial contents are all zero.
- States: IDLE, WAIT, RESP.
- req_ready = (state == IDLE) and not rst. It is combinational and does not depend on req_valid.
- Acceptance occurs on a rising edge with req_valid and req_ready both 1. At that edge:
  - Error check: err = (req_addr[1:0] != 0) or (req_addr >= DEPTH*4).
  - Store without error: for each i with req_be[i] = 1, mem[req_addr>>2] byte i <= req_wdata byte i. req_be = 0 writes nothing but still responds normally.
  - Load without error: rsp_rdata <= mem[req_addr>>2], full word; req_be is ignored.
  - Store or any error: rsp_rdata <= 0.
  - rsp_err <= err. An erroring store writes nothing.
  - Next state: RESP with rsp_valid <= 1 if WAIT_STATES == 0; otherwise WAIT with the counter loaded to WAIT_STATES.
- WAIT: counter decrements each cycle. When the counter is 1, next state is RESP and rsp_valid <= 1.
- Latency: rsp_valid is first high in the cycle following edge (accept + WAIT_STATES). With WAIT_STATES = 2 and acceptance at edge E0, rsp_valid is high after edge E2.
- RESP:
  - rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready = 1 at a rising edge.
  - At that edge: rsp_valid <= 0, rsp_rdata <= 0, rsp_err <= 0, state <= IDLE.
  - No new request is accepted in the same edge as a response handshake. Minimum spacing between acceptances is WAIT_STATES + 2 cycles.
- Inputs outside the acceptance edge are ignored. req_* may change freely in WAIT and RESP.
- Ordering: the memory update happens at acceptance, so a load accepted after a store always returns the stored data.
- Reset mid-operation:
  - A store already accepted remains committed.
  - The pending response is discarded, with no rsp_valid pulse.
  - After rst deasserts, the block returns to IDLE.
- rsp_ready while in IDLE or WAIT has no effect.

Test Plan:
1. Store then load: store addr 0x10, data 0xDEADBEEF, be 1111; then load 0x10 -> rdata 0xDEADBEEF, err 0; rsp_valid appears 2 cycles after each acceptance (WAIT_STATES=2).
2. Byte lanes: word 0x20 preset to 0x11223344; store data 0xAABBCCDD with be 0101 -> load 0x20 returns 0x11BB33DD.
3. Errors:
   - Load 0x13 -> err 1, rdata 0.
   - Store to 0x400 (DEPTH=256) -> err 1, and a load of 0x0 afterwards shows unchanged contents.
4. Backpressure: hold rsp_ready 0 for 5 cycles -> rsp_valid/rdata stable and req_ready 0 throughout; rsp_ready 1 -> next cycle rsp_valid 0, req_ready 1.
5. Reset mid-transaction: accept store 0x5A5A5A5A to 0x8; assert rst during WAIT -> rsp_valid never rises and req_ready is 0 during rst; after release, load 0x8 returns 0x5A5A5A5A.
6. WAIT_STATES=0 instance: back-to-back loads with rsp_ready tied 1 -> rsp_valid high the cycle after each acceptance; acceptances every 2 cycles.
